// File: rtl/t05_key_entry.sv
// -----------------------------------------------------------------------------
// t05_key_entry
// Keypad entry controller. Turns each synchronized key press into one key
// event, with a release hold-off that rejects bounce. Digit codes 0-15 are
// shifted into a DIGITS-nibble entry buffer. Codes 16-18 are the ENTER,
// BACKSPACE and CLEAR commands, and code 19 is reserved. ENTER latches the
// buffer into result_data and pulses result_valid for one cycle.
//
// Optional feature (macro T05_KEY_REPEAT_EN):
//   While a key stays held, the captured digit or BACKSPACE code is processed
//   again every REPEAT_CYCLES cycles.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   key_code     in   5-bit key index from the synchronizer (0-19)
//   key_strobe   in   synchronized key-pressed level
//   buf_data     out  live entry buffer; the newest digit is in bits [3:0]
//   buf_count    out  number of digits currently in the buffer
//   result_data  out  buffer value latched on ENTER
//   result_valid out  1-cycle pulse when result_data updates
//   key_event    out  1-cycle pulse per accepted press or repeat
//   buf_full     out  high when buf_count == DIGITS
// -----------------------------------------------------------------------------
// state   | meaning
// IDLE    | released and debounced; the next strobe high is accepted
// HELD    | key is down (or was held through reset); wait for release
// HOLDOFF | key released; count low cycles before a new press is accepted
// -----------------------------------------------------------------------------
module t05_key_entry #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [4:0]                   key_code,
    input  logic                         key_strobe,
    output logic [4*DIGITS-1:0]          buf_data,
    output logic [$clog2(DIGITS+1)-1:0]  buf_count,
    output logic [4*DIGITS-1:0]          result_data,
    output logic                         result_valid,
    output logic                         key_event,
    output logic                         buf_full
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
`ifdef T05_KEY_REPEAT_EN
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int NW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
    localparam logic [NW-1:0] DEB_LAST = NW'(DEBOUNCE_CYCLES - 1);
`ifdef T05_KEY_REPEAT_EN
    localparam logic [NW-1:0] REP_LAST = NW'(REPEAT_CYCLES - 1);
`endif

    localparam logic [4:0] CODE_ENTER = 5'd16;
    localparam logic [4:0] CODE_BKSP  = 5'd17;
    localparam logic [4:0] CODE_CLEAR = 5'd18;
    localparam logic [4:0] CODE_RSVD  = 5'd19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  buf_q, buf_d;
    logic [CW-1:0]  count_q, count_d;
    logic [BW-1:0]  result_q, result_d;
    logic           result_valid_q, result_valid_d;
    logic           key_event_q, key_event_d;
    logic           buf_full_q, buf_full_d;
`ifdef T05_KEY_REPEAT_EN
    logic [4:0]     code_q, code_d;
`endif

    logic           proc_en;
    logic [4:0]     proc_code;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        buf_d          = buf_q;
        count_d        = count_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        key_event_d    = 1'b0;
        proc_en        = 1'b0;
        proc_code      = key_code;
`ifdef T05_KEY_REPEAT_EN
        code_d         = code_q;
`endif

        case (state_q)
            IDLE: begin
                if (key_strobe) begin
                    proc_en = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
`ifdef T05_KEY_REPEAT_EN
                    code_d  = key_code;
`endif
                end
            end
            HELD: begin
                if (!key_strobe) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end
`ifdef T05_KEY_REPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    // Only digits and BACKSPACE auto-repeat.
                    if (code_q < CODE_ENTER || code_q == CODE_BKSP) begin
                        proc_en   = 1'b1;
                        proc_code = code_q;
                    end
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
`endif
            end
            HOLDOFF: begin
                if (key_strobe) begin
                    // Bounce: go back to HELD without an event.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            default: begin
                state_d = HELD;
                cnt_d   = '0;
            end
        endcase

        if (proc_en) begin
            key_event_d = 1'b1;
            if (proc_code < CODE_ENTER) begin
                if (count_q != DIGITS_C) begin
                    buf_d   = (buf_q << 4) | BW'(proc_code[3:0]);
                    count_d = count_q + CW'(1);
                end
            end else if (proc_code == CODE_ENTER) begin
                if (count_q != '0) begin
                    result_d       = buf_q;
                    result_valid_d = 1'b1;
                    buf_d          = '0;
                    count_d        = '0;
                end
            end else if (proc_code == CODE_BKSP) begin
                if (count_q != '0) begin
                    buf_d   = buf_q >> 4;
                    count_d = count_q - CW'(1);
                end
            end else if (proc_code == CODE_CLEAR) begin
                buf_d   = '0;
                count_d = '0;
            end
        end

        buf_full_d = (count_d == DIGITS_C);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Start in HELD so that a key held through reset is not accepted.
            state_q        <= HELD;
            cnt_q          <= '0;
            buf_q          <= '0;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            key_event_q    <= 1'b0;
            buf_full_q     <= 1'b0;
`ifdef T05_KEY_REPEAT_EN
            // The reserved code never repeats, so a held key cannot produce events.
            code_q         <= CODE_RSVD;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_q          <= buf_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            key_event_q    <= key_event_d;
            buf_full_q     <= buf_full_d;
`ifdef T05_KEY_REPEAT_EN
            code_q         <= code_d;
`endif
        end
    end

    assign buf_data     = buf_q;
    assign buf_count    = count_q;
    assign result_data  = result_q;
    assign result_valid = result_valid_q;
    assign key_event    = key_event_q;
    assign buf_full     = buf_full_q;

endmodule
